// File: rtl/cpu_pkg.sv
// Shared CPU types and constants for the register-file write path.
// Contents: reg_addr_t / word_t typedefs, register count, and the
// hard-wired zero register index.
package cpu_pkg;

    typedef logic [4:0]  reg_addr_t;
    typedef logic [31:0] word_t;

    localparam int        NUM_REGS = 32;
    localparam reg_addr_t REG_ZERO = 5'd0;

endpackage

// File: rtl/decoder_5_to_32.sv
// One-hot decoder from a 5-bit register address to a 32-bit vector.
// Ports:
//   ena    - when low the output is all zeros
//   addr   - register address to decode
//   onehot - single bit set at position addr (if ena)
module decoder_5_to_32
    import cpu_pkg::*;
(
    input  logic                ena,
    input  reg_addr_t           addr,
    output logic [NUM_REGS-1:0] onehot
);

    always_comb begin
        onehot = '0;
        if (ena) begin
            onehot[addr] = 1'b1;
        end
    end

endmodule

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard for the 32-entry register file.
// One bit per register marks an outstanding write; x0 never goes pending.
// Ports:
//   clk, rst            - clock, async active-high reset
//   set_ena, set_addr   - mark a register pending (issue)
//   clr_ena, clr_addr   - retire a register (register file commit)
//   rd_addr0, rd_addr1  - decode read addresses
//   busy0, busy1        - pending status of the addressed registers
module regfile_scoreboard
    import cpu_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      set_ena,
    input  reg_addr_t set_addr,
    input  logic      clr_ena,
    input  reg_addr_t clr_addr,
    input  reg_addr_t rd_addr0,
    input  reg_addr_t rd_addr1,
    output logic      busy0,
    output logic      busy1
);

    logic [NUM_REGS-1:0] pending;
    logic [NUM_REGS-1:0] pending_next;
    logic [NUM_REGS-1:0] set_vec;
    logic [NUM_REGS-1:0] clr_vec;

    decoder_5_to_32 u_set_dec (
        .ena    (set_ena),
        .addr   (set_addr),
        .onehot (set_vec)
    );

    decoder_5_to_32 u_clr_dec (
        .ena    (clr_ena),
        .addr   (clr_addr),
        .onehot (clr_vec)
    );

    // Clear is applied first so a re-issue to the register being committed
    // on the same edge keeps it pending for the newer instruction.
    always_comb begin
        pending_next           = (pending & ~clr_vec) | set_vec;
        pending_next[REG_ZERO] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= '0;
        end else begin
            pending <= pending_next;
        end
    end

    assign busy0 = pending[rd_addr0];
    assign busy1 = pending[rd_addr1];

endmodule

// File: rtl/regfile_writeback.sv
// Write-side controller for the 32x32 register file.
// Arbitrates ALU and load-unit results (load has priority, ALU gets a
// forced grant after STARVE_LIMIT stalled cycles), registers the winner
// onto the write channel, drops x0 writes, and tracks pending writes.
// Ports:
//   clk, rst                       - clock, async active-high reset
//   issue_valid, issue_rd          - destination of a newly issued instruction
//   alu_valid/ready/rd/data        - ALU writeback handshake
//   mem_valid/ready/rd/data        - load writeback handshake
//   wr_ena, wr_addr, wr_data       - registered register file write channel
//   rd_addr0/1, busy0/1            - hazard query for decode
module regfile_writeback
    import cpu_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      issue_valid,
    input  reg_addr_t issue_rd,
    input  logic      alu_valid,
    output logic      alu_ready,
    input  reg_addr_t alu_rd,
    input  word_t     alu_data,
    input  logic      mem_valid,
    output logic      mem_ready,
    input  reg_addr_t mem_rd,
    input  word_t     mem_data,
    output logic      wr_ena,
    output reg_addr_t wr_addr,
    output word_t     wr_data,
    input  reg_addr_t rd_addr0,
    input  reg_addr_t rd_addr1,
    output logic      busy0,
    output logic      busy1
);

    localparam int              CNT_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] starve_cnt;
    logic             force_alu;
    logic             alu_xfer;
    logic             mem_xfer;

    assign force_alu = (starve_cnt == CNT_MAX);

    // The rst term only matters for alu_ready; the counter is already zero
    // in reset so mem_ready is 1 without it, but it is kept for symmetry.
    assign alu_ready = rst || !mem_valid || force_alu;
    assign mem_ready = rst || !(force_alu && alu_valid);

    // Mutually exclusive by construction: when both are valid exactly one
    // of the readies is high.
    assign alu_xfer = alu_valid && alu_ready;
    assign mem_xfer = mem_valid && mem_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (alu_xfer) begin
            starve_cnt <= '0;
        end else if (alu_valid && (starve_cnt != CNT_MAX)) begin
            starve_cnt <= starve_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ena  <= 1'b0;
            wr_addr <= REG_ZERO;
            wr_data <= '0;
        end else if (mem_xfer && (mem_rd != REG_ZERO)) begin
            wr_ena  <= 1'b1;
            wr_addr <= mem_rd;
            wr_data <= mem_data;
        end else if (alu_xfer && (alu_rd != REG_ZERO)) begin
            wr_ena  <= 1'b1;
            wr_addr <= alu_rd;
            wr_data <= alu_data;
        end else begin
            wr_ena  <= 1'b0;
        end
    end

    regfile_scoreboard u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .set_ena  (issue_valid),
        .set_addr (issue_rd),
        .clr_ena  (wr_ena),
        .clr_addr (wr_addr),
        .rd_addr0 (rd_addr0),
        .rd_addr1 (rd_addr1),
        .busy0    (busy0),
        .busy1    (busy1)
    );

endmodule

// File: doc/regfile_writeback.md
# regfile_writeback

Write-side controller for the CPU's 32×32 register file. Arbitrates writeback results from the ALU and load unit over valid/ready handshakes, registers the winner onto the register file's write channel, suppresses writes to x0, and keeps a per-register pending scoreboard so decode can detect read-after-write hazards on its two read addresses.

## Interface
- STARVE_LIMIT, default 4: consecutive stalled ALU cycles before the ALU is force-granted.
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- issue_valid  input  1  an instruction with a destination register is issued this cycle
- issue_rd  input  5  destination register of the issued instruction
- alu_valid  input  1  ALU result available
- alu_ready  output  1  ALU result accepted this cycle
- alu_rd  input  5  ALU destination register
- alu_data  input  32  ALU result
- mem_valid  input  1  load result available
- mem_ready  output  1  load result accepted this cycle
- mem_rd  input  5  load destination register
- mem_data  input  32  load result
- wr_ena  output  1  register file write enable (registered)
- wr_addr  output  5  register file write address (registered)
- wr_data  output  32  register file write data (registered)
- rd_addr0, rd_addr1  input  5 each  decode read addresses to check
- busy0, busy1  output  1 each  addressed register has a pending write

## Operation
- Handshake: transfer occurs when valid && ready in the same cycle. Payload must remain stable while valid && !ready.
- Arbitration, combinational on current inputs:
  - Default priority: mem over alu. alu_ready = !mem_valid || force_alu; mem_ready = !(force_alu && alu_valid).
  - Exactly one source is accepted per cycle. A lone valid source is always accepted.
- Starvation counter (width ceil(log2(STARVE_LIMIT+1))):
  - Increments each cycle alu_valid && !alu_ready, saturating at STARVE_LIMIT.
  - Clears on any ALU transfer.
  - force_alu = (count == STARVE_LIMIT).
- Output stage, registered:
  - On a transfer with rd != 0, the next edge loads wr_ena=1 with that rd/data.
  - Otherwise the next edge loads wr_ena=0. wr_addr/wr_data hold their previous value when wr_ena=0.
  - A transfer with rd=0 is accepted but never produces wr_ena.
- Scoreboard, 32 bits, bit 0 hard-wired 0:
  - Set on issue_valid for issue_rd != 0.
  - Cleared on the edge where wr_ena=1 for wr_addr, i.e. the same edge the register file commits.
  - If the same register is set and cleared on the same edge, set wins.
  - busyN = scoreboard[rd_addrN]; this is combinational and adds no cycle.
- Reset mid-operation:
  - All state clears immediately: wr_ena=0, wr_addr=0, wr_data=0, scoreboard=0, counter=0.
  - A transfer in the reset cycle is lost.
  - While rst is high, alu_ready=1, mem_ready=1, busy0=0, busy1=0.

## Timing
- Latency: transfer in cycle N → wr_ena/wr_addr/wr_data valid in cycle N+1 → register file holds the value from cycle N+2.
- busy for that register drops at the start of cycle N+2, not N+1.
- Throughput: one writeback per cycle. No downstream backpressure exists.
- Under continuous mem_valid, the ALU waits at most STARVE_LIMIT cycles and is granted on stall cycle STARVE_LIMIT+1.
- Output reset values: wr_ena=0, wr_addr=0, wr_data=0. busy0/busy1 are 0 after reset.

## Structure
- Shared package `cpu_pkg`: typedef reg_addr_t (logic [4:0]), typedef word_t (logic [31:0]), constant NUM_REGS=32, constant REG_ZERO=5'd0.
- Sub-module `regfile_scoreboard` contains the 32-bit pending vector, the set/clear logic with set priority, and the two read ports.
- decoder_5_to_32 is reused for the set and clear one-hot vectors.
- Arbiter, starvation counter and output register stay in the top module.

## Test plan
- **Reset:** assert rst asynchronously mid-cycle → wr_ena=0, wr_addr=0, wr_data=0, busy0=busy1=0 immediately; pending scoreboard bits are cleared.
- **Single ALU write:** issue_rd=5, then alu_valid with rd=5, data=0xDEADBEEF in cycle N → alu_ready=1 in N; wr_ena=1, wr_addr=5, wr_data=0xDEADBEEF in N+1; busy (rd_addr0=5) is 1 through N+1 and 0 in N+2.
- **Collision:** alu (rd=3, 0x11) and mem (rd=4, 0x22) both valid in cycle N → mem wins, alu_ready=0; x4 written in N+1, x3 written in N+2.
- **Starvation:** mem_valid held high with rd=7 for 10 cycles, alu_valid high with rd=9, STARVE_LIMIT=4 → alu_ready=0 for 4 cycles, then 1 in cycle 5 with mem_ready=0; the counter then clears.
- **x0 suppression:** alu_valid with rd=0, data=0xFFFFFFFF → alu_ready=1, wr_ena stays 0; issue_rd=0 leaves busy for address 0 at 0.
- **Set/clear race:** x6 pending and wr_ena=1 for x6 on the same edge as issue_valid with issue_rd=6 → busy for x6 stays 1 afterwards.
